// File: rtl/morse_pkg.sv
// Shared state encoding and Morse timing constants (in units) for the Morse sequencer.
package morse_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StElemGap,
        StCharGap,
        StWordGap
    } state_e;

    localparam logic [2:0] DotUnits       = 3'd1;
    localparam logic [2:0] DashUnits      = 3'd3;
    localparam logic [2:0] ElemGapUnits   = 3'd1;
    localparam logic [2:0] CharGapUnits   = 3'd3;
    localparam logic [2:0] WordExtraUnits = 3'd4;
    localparam logic [2:0] MaxLen         = 3'd5;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > MaxLen) ? MaxLen : len;
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Upstream descriptor handshake for the Morse sequencer.
// MORSE_SPEED_CFG_EN adds the per-descriptor speed_div field.
interface morse_sequencer_if #(
    parameter int unsigned DIV_W = 28
);
    logic       sym_valid;
    logic       sym_ready;
    logic [4:0] sym_pattern;
    logic [2:0] sym_len;
    logic       sym_space;
`ifdef MORSE_SPEED_CFG_EN
    logic [DIV_W-1:0] speed_div;

    modport master (output sym_valid, sym_pattern, sym_len, sym_space, speed_div,
                    input sym_ready);
    modport slave  (input sym_valid, sym_pattern, sym_len, sym_space, speed_div,
                    output sym_ready);
`else
    modport master (output sym_valid, sym_pattern, sym_len, sym_space, input sym_ready);
    modport slave  (input sym_valid, sym_pattern, sym_len, sym_space, output sym_ready);
`endif
endinterface

// File: rtl/morse_unit_timer.sv
// Restartable unit-time divider: unit_tick pulses on the last cycle of every unit.
module morse_unit_timer #(
    parameter int unsigned DIV_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] limit,
    output logic             unit_tick
);

    logic [DIV_W-1:0] cnt_q;

    assign unit_tick = ~restart & (cnt_q == limit - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst || restart || unit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Turns one Morse descriptor (or word-space request) into a timed key waveform.
// Define MORSE_SPEED_CFG_EN to take cycles/unit from speed_div at accept time.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned DIV_W       = 28,
    parameter int unsigned UNIT_CYCLES = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    morse_sequencer_if.slave   sym,
    output logic               key_out,
    output logic               busy,
    output logic               char_done
);

    state_e           state_q;
    logic             ready_q;
    logic             zero_done_q;
    logic [4:0]       pat_q;
    logic [2:0]       len_q;
    logic [2:0]       elem_q;
    logic [2:0]       phase_q;
    logic [2:0]       phase_len;
    logic [DIV_W-1:0] unit_limit;
    logic             unit_tick;
    logic             timer_restart;
    logic             accept;
    logic             phase_done;
    logic             cur_dash;

`ifdef MORSE_SPEED_CFG_EN
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_W'(1);
        end else if (accept) begin
            div_q <= (sym.speed_div == '0) ? DIV_W'(1) : sym.speed_div;
        end
    end

    assign unit_limit = div_q;
`else
    assign unit_limit = DIV_W'(UNIT_CYCLES);
`endif

    // Held at zero while idle; every later phase entry coincides with a wrap to zero.
    assign timer_restart = (state_q == StIdle);

    morse_unit_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (timer_restart),
        .limit    (unit_limit),
        .unit_tick(unit_tick)
    );

    assign accept        = sym.sym_valid & ready_q;
    assign sym.sym_ready = ready_q;
    assign cur_dash      = pat_q[3'd4 - elem_q];
    assign busy          = (state_q != StIdle);

    always_comb begin
        phase_len = ElemGapUnits;
        unique case (state_q)
            StMark:    phase_len = cur_dash ? DashUnits : DotUnits;
            StCharGap: phase_len = CharGapUnits;
            StWordGap: phase_len = WordExtraUnits;
            default:   phase_len = ElemGapUnits;
        endcase
    end

    assign phase_done = unit_tick & (phase_q == phase_len - 3'd1);
    assign char_done  = zero_done_q |
                        (phase_done & ((state_q == StCharGap) | (state_q == StWordGap)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            key_out     <= 1'b0;
            ready_q     <= 1'b0;
            zero_done_q <= 1'b0;
            pat_q       <= '0;
            len_q       <= '0;
            elem_q      <= '0;
            phase_q     <= '0;
        end else begin
            zero_done_q <= 1'b0;
            if (state_q == StIdle) begin
                if (accept) begin
                    ready_q <= 1'b0;
                    pat_q   <= sym.sym_pattern;
                    len_q   <= clamp_len(sym.sym_len);
                    elem_q  <= '0;
                    phase_q <= '0;
                    if (sym.sym_space) begin
                        state_q <= StWordGap;
                    end else if (sym.sym_len == 3'd0) begin
                        zero_done_q <= 1'b1;
                    end else begin
                        state_q <= StMark;
                        key_out <= 1'b1;
                    end
                end else begin
                    ready_q <= 1'b1;
                end
            end else if (phase_done) begin
                phase_q <= '0;
                case (state_q)
                    StMark: begin
                        key_out <= 1'b0;
                        if (elem_q + 3'd1 == len_q) begin
                            state_q <= StCharGap;
                        end else begin
                            state_q <= StElemGap;
                            elem_q  <= elem_q + 3'd1;
                        end
                    end
                    StElemGap: begin
                        state_q <= StMark;
                        key_out <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                endcase
            end else if (unit_tick) begin
                phase_q <= phase_q + 3'd1;
            end
        end
    end

endmodule
